// File: rtl/math_pkg.sv
// Shared fixed-point widths, saturation constants, FSM states and helpers for the math blocks.
// The width macros normally arrive from constants.h; these defaults match it when it is absent.
`ifndef FLOAT_BITS
`define FLOAT_BITS 32
`endif
`ifndef FLOAT_DCM_BITS
`define FLOAT_DCM_BITS 16
`endif

package math_pkg;

    localparam int W      = `FLOAT_BITS;
    localparam int D      = `FLOAT_DCM_BITS;
    localparam int PROD_W = 2 * W + 1;
    localparam int DVD_W  = PROD_W + D;
    localparam int CMP_W  = PROD_W + W - 1;

    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, DIV1, DIV2, DONE} state_e;

    typedef struct packed {
        logic [W-1:0] v1;
        logic [W-1:0] v2;
        logic [W-1:0] a11;
        logic [W-1:0] a12;
        logic [W-1:0] a21;
        logic [W-1:0] a22;
    } operands_t;

    // a*b - c*d, exact at 2W+1 bits with scale 2^(2D).
    function automatic logic signed [PROD_W-1:0] cross_diff(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b,
        input logic signed [W-1:0] c,
        input logic signed [W-1:0] d
    );
        logic signed [PROD_W-1:0] ab;
        logic signed [PROD_W-1:0] cd;
        ab = PROD_W'(a) * PROD_W'(b);
        cd = PROD_W'(c) * PROD_W'(d);
        return ab - cd;
    endfunction

    function automatic logic [PROD_W-1:0] magnitude(input logic signed [PROD_W-1:0] x);
        return x[PROD_W-1] ? -x : x;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per active cycle, W cycles per division.
// The start cycle already performs the first step, and quotient_o is valid in the cycle done_o is high.
module seq_divider
    import math_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DVD_W-1:0]  dividend_i,
    input  logic [PROD_W-1:0] divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [W-1:0]      quotient_o
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    logic [CMP_W-1:0] rem_q, rem_d, rem_cur;
    logic [CMP_W-1:0] dsr_q, dsr_d, dsr_cur;
    logic [W-1:0]     quo_q, quo_d, quo_cur;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;
    logic             busy_q, busy_d;
    logic             active, take;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_o  = 1'b0;
        active  = start_i || busy_q;
        rem_cur = start_i ? CMP_W'(dividend_i) : rem_q;
        dsr_cur = start_i ? {divisor_i, {(W-1){1'b0}}} : dsr_q;
        quo_cur = start_i ? '0 : quo_q;
        cnt_cur = start_i ? '0 : cnt_q;
        take    = rem_cur >= dsr_cur;
        if (active) begin
            rem_d  = take ? rem_cur - dsr_cur : rem_cur;
            dsr_d  = dsr_cur >> 1;
            quo_d  = {quo_cur[W-2:0], take};
            cnt_d  = cnt_cur + CNT_W'(1);
            done_o = (cnt_cur == LAST);
            busy_d = !done_o;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dsr_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign quotient_o = quo_d;

endmodule

// File: rtl/matrix_solve.sv
// Solves u . A = v for the 2x2 row-vector transform with Cramer's rule and one shared divider.
// Fixed-point signed operands; results saturate when the quotient does not fit in W bits.
module matrix_solve
    import math_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] v1,
    input  logic [W-1:0] v2,
    input  logic [W-1:0] a11,
    input  logic [W-1:0] a12,
    input  logic [W-1:0] a21,
    input  logic [W-1:0] a22,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] u1,
    output logic [W-1:0] u2,
    output logic         singular,
    output logic         saturated
);

    state_e                   state_q, state_d;
    operands_t                ops_q, ops_d;
    logic signed [PROD_W-1:0] det_q, det_d, n1_q, n1_d, n2_q, n2_d;
    logic [W-1:0]             u1_q, u1_d, u2_q, u2_d;
    logic                     sing_q, sing_d, sat_q, sat_d;

    logic signed [PROD_W-1:0] det_c, num_sel;
    logic [PROD_W-1:0]        num_mag, det_mag;
    logic [DVD_W-1:0]         dividend;
    logic [W-1:0]             quotient, comp_result;
    logic                     sat_hit, neg, div_start, div_busy, div_done;

    assign det_c    = cross_diff(ops_q.a11, ops_q.a22, ops_q.a12, ops_q.a21);
    assign num_sel  = (state_q == DIV2) ? n2_q : n1_q;
    assign num_mag  = magnitude(num_sel);
    assign det_mag  = magnitude(det_q);
    assign dividend = {num_mag, {D{1'b0}}};
    assign neg      = num_sel[PROD_W-1] ^ det_q[PROD_W-1];

    // A quotient of 2^(W-1) or more would reach the sign bit, so clamp instead of dividing.
    assign sat_hit     = CMP_W'(dividend) >= {det_mag, {(W-1){1'b0}}};
    assign comp_result = sat_hit ? (neg ? SAT_NEG : SAT_POS) : (neg ? -quotient : quotient);

    seq_divider u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .dividend_i (dividend),
        .divisor_i  (det_mag),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (quotient)
    );

    always_comb begin
        state_d   = state_q;
        ops_d     = ops_q;
        det_d     = det_q;
        n1_d      = n1_q;
        n2_d      = n2_q;
        u1_d      = u1_q;
        u2_d      = u2_q;
        sing_d    = sing_q;
        sat_d     = sat_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ops_d   = {v1, v2, a11, a12, a21, a22};
                    sing_d  = 1'b0;
                    sat_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                det_d = det_c;
                n1_d  = cross_diff(ops_q.v1, ops_q.a22, ops_q.v2, ops_q.a21);
                n2_d  = cross_diff(ops_q.v2, ops_q.a11, ops_q.v1, ops_q.a12);
                if (det_c == '0) begin
                    sing_d  = 1'b1;
                    u1_d    = '0;
                    u2_d    = '0;
                    state_d = DONE;
                end else begin
                    state_d = DIV1;
                end
            end
            DIV1, DIV2: begin
                div_start = !sat_hit && !div_busy;
                if (sat_hit || div_done) begin
                    sat_d = sat_q | sat_hit;
                    if (state_q == DIV1) begin
                        u1_d    = comp_result;
                        state_d = DIV2;
                    end else begin
                        u2_d    = comp_result;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ops_q   <= '0;
            det_q   <= '0;
            n1_q    <= '0;
            n2_q    <= '0;
            u1_q    <= '0;
            u2_q    <= '0;
            sing_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ops_q   <= ops_d;
            det_q   <= det_d;
            n1_q    <= n1_d;
            n2_q    <= n2_d;
            u1_q    <= u1_d;
            u2_q    <= u2_d;
            sing_q  <= sing_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign u1        = u1_q;
    assign u2        = u2_q;
    assign singular  = sing_q;
    assign saturated = sat_q;

endmodule
